// File: rtl/seven_seg_driver.sv
// Four-digit multiplexed seven-segment driver with shadow/active digit registers.
// Host writes land in shadow; a commit copies all four digits to active at the next frame boundary.
module seven_seg_driver #(
    parameter int SCAN_DIV = 100000,
    parameter int CNT_W    = $clog2(SCAN_DIV)
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [1:0] wr_addr,
    input  logic [3:0] wr_data,
    input  logic       wr_dp,
    input  logic       wr_blank,
    input  logic       commit,
    output logic       pending,
    output logic       frame_tick,
    output logic [3:0] anode,
    output logic [6:0] cathode,
    output logic       dp
);

    typedef struct packed {
        logic [3:0] val;
        logic       dp;
        logic       blank;
    } digit_t;

    localparam digit_t          RST_DIGIT = '{val: 4'h0, dp: 1'b0, blank: 1'b1};
    localparam logic [CNT_W-1:0] TC       = CNT_W'(SCAN_DIV - 1);

    digit_t [3:0]     shadow_q;
    digit_t [3:0]     active_q;
    logic [CNT_W-1:0] presc;
    logic [1:0]       idx;
    logic             tc;
    logic             boundary;
    digit_t           cur;

    assign tc       = (presc == TC);
    assign boundary = tc && (idx == 2'd3);
    assign cur      = active_q[idx];

    // Active-low segment pattern, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_seg(input logic [3:0] v);
        case (v)
            4'h0:    hex_seg = 7'b1000000;
            4'h1:    hex_seg = 7'b1111001;
            4'h2:    hex_seg = 7'b0100100;
            4'h3:    hex_seg = 7'b0110000;
            4'h4:    hex_seg = 7'b0011001;
            4'h5:    hex_seg = 7'b0010010;
            4'h6:    hex_seg = 7'b0000010;
            4'h7:    hex_seg = 7'b1111000;
            4'h8:    hex_seg = 7'b0000000;
            4'h9:    hex_seg = 7'b0010000;
            4'hA:    hex_seg = 7'b0001000;
            4'hB:    hex_seg = 7'b0000011;
            4'hC:    hex_seg = 7'b1000110;
            4'hD:    hex_seg = 7'b0100001;
            4'hE:    hex_seg = 7'b0000110;
            default: hex_seg = 7'b0001110;
        endcase
    endfunction

    always_ff @(posedge clock) begin
        if (!reset) begin
            presc      <= '0;
            idx        <= '0;
            pending    <= 1'b0;
            frame_tick <= 1'b0;
            anode      <= 4'b1111;
            cathode    <= 7'b1111111;
            dp         <= 1'b1;
            for (int i = 0; i < 4; i++) begin
                shadow_q[i] <= RST_DIGIT;
                active_q[i] <= RST_DIGIT;
            end
        end else begin
            presc      <= tc ? '0 : presc + CNT_W'(1);
            if (tc) idx <= idx + 2'd1;
            frame_tick <= boundary;

            anode   <= ~(4'b0001 << idx);
            cathode <= cur.blank ? 7'b1111111 : hex_seg(cur.val);
            dp      <= cur.blank | ~cur.dp;

            // A commit arriving with the transfer re-arms for the next frame.
            if (boundary && pending) begin
                active_q <= shadow_q;
                pending  <= commit;
            end else if (commit) begin
                pending <= 1'b1;
            end

            if (wr_en) shadow_q[wr_addr] <= '{val: wr_data, dp: wr_dp, blank: wr_blank};
        end
    end

endmodule

// File: tb/tb_seven_seg_driver.sv
// Bench for seven_seg_driver: per-cycle reference model feeding an expected-output queue,
// a decode vector table, and directed sequences for commit/boundary/reset corners.
module tb_seven_seg_driver;

    localparam int SD = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       wr_en = 1'b0;
    logic [1:0] wr_addr = '0;
    logic [3:0] wr_data = '0;
    logic       wr_dp = 1'b0;
    logic       wr_blank = 1'b0;
    logic       commit = 1'b0;
    logic       pending, frame_tick, dp;
    logic [3:0] anode;
    logic [6:0] cathode;

    int errors = 0;
    int checks = 0;

    seven_seg_driver #(.SCAN_DIV(SD)) dut (
        .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_dp(wr_dp), .wr_blank(wr_blank), .commit(commit),
        .pending(pending), .frame_tick(frame_tick), .anode(anode),
        .cathode(cathode), .dp(dp)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] amap(input logic [1:0] i);
        case (i)
            2'd0:    amap = 4'b1110;
            2'd1:    amap = 4'b1101;
            2'd2:    amap = 4'b1011;
            default: amap = 4'b0111;
        endcase
    endfunction

    function automatic logic [6:0] dec(input logic [3:0] v);
        case (v)
            4'h0: dec = 7'b1000000;  4'h1: dec = 7'b1111001;
            4'h2: dec = 7'b0100100;  4'h3: dec = 7'b0110000;
            4'h4: dec = 7'b0011001;  4'h5: dec = 7'b0010010;
            4'h6: dec = 7'b0000010;  4'h7: dec = 7'b1111000;
            4'h8: dec = 7'b0000000;  4'h9: dec = 7'b0010000;
            4'hA: dec = 7'b0001000;  4'hB: dec = 7'b0000011;
            4'hC: dec = 7'b1000110;  4'hD: dec = 7'b0100001;
            4'hE: dec = 7'b0000110;  default: dec = 7'b0001110;
        endcase
    endfunction

    // Reference model state and expected-output queue {anode,cathode,dp,pending,frame_tick}.
    int         m_cnt = 0;
    logic [1:0] m_idx = '0;
    logic       m_pend = 1'b0;
    logic [3:0] sh_val[4], ac_val[4];
    logic       sh_dp[4], ac_dp[4], sh_bl[4], ac_bl[4];
    logic [13:0] exp_q[$];

    function automatic logic m_bnd();
        return (m_cnt == SD - 1) && (m_idx == 2'd3);
    endfunction

    function automatic logic m_next_pend();
        if (m_bnd() && m_pend) return commit;
        return commit ? 1'b1 : m_pend;
    endfunction

    always @(posedge clock) begin
        if (!reset) begin
            exp_q.push_back({4'b1111, 7'b1111111, 1'b1, 1'b0, 1'b0});
            m_cnt  <= 0;
            m_idx  <= '0;
            m_pend <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                sh_val[i] <= '0; sh_dp[i] <= 1'b0; sh_bl[i] <= 1'b1;
                ac_val[i] <= '0; ac_dp[i] <= 1'b0; ac_bl[i] <= 1'b1;
            end
        end else begin
            exp_q.push_back({amap(m_idx),
                             ac_bl[m_idx] ? 7'b1111111 : dec(ac_val[m_idx]),
                             ac_bl[m_idx] | ~ac_dp[m_idx],
                             m_next_pend(), m_bnd()});
            m_cnt  <= (m_cnt == SD - 1) ? 0 : m_cnt + 1;
            if (m_cnt == SD - 1) m_idx <= m_idx + 2'd1;
            m_pend <= m_next_pend();
            if (m_bnd() && m_pend) begin
                for (int i = 0; i < 4; i++) begin
                    ac_val[i] <= sh_val[i]; ac_dp[i] <= sh_dp[i]; ac_bl[i] <= sh_bl[i];
                end
            end
            if (wr_en) begin
                sh_val[wr_addr] <= wr_data; sh_dp[wr_addr] <= wr_dp; sh_bl[wr_addr] <= wr_blank;
            end
        end
    end

    always @(negedge clock) begin
        if (exp_q.size() > 0)
            check("sb", 32'({anode, cathode, dp, pending, frame_tick}), 32'(exp_q.pop_front()));
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Leaves the bench inside the cycle whose closing edge is a frame boundary.
    task automatic wait_bnd();
        int n = 0;
        while (!(m_cnt == SD - 1 && m_idx == 2'd3) && n < 40) begin
            step();
            n++;
        end
        if (n >= 40) begin
            checks++;
            errors++;
            $display("FAIL bnd_timeout: no frame boundary within %0d cycles", n);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [3:0] d, input logic p, input logic b);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_dp = p; wr_blank = b;
        step();
        wr_en = 1'b0;
    endtask

    task automatic do_commit();
        commit = 1'b1;
        step();
        commit = 1'b0;
    endtask

    typedef struct {
        logic [3:0] d;
        logic       p;
        logic       b;
        logic [6:0] seg;
        logic       dpo;
    } vec_t;

    vec_t vecs[18];

    initial begin : wdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [6:0] exp3[4];
        exp3[0] = 7'b1111001; exp3[1] = 7'b0100100; exp3[2] = 7'b0110000; exp3[3] = 7'b0001110;

        vecs[0]  = '{4'h0, 1'b0, 1'b0, 7'b1000000, 1'b1};
        vecs[1]  = '{4'h1, 1'b1, 1'b0, 7'b1111001, 1'b0};
        vecs[2]  = '{4'h2, 1'b0, 1'b0, 7'b0100100, 1'b1};
        vecs[3]  = '{4'h3, 1'b1, 1'b0, 7'b0110000, 1'b0};
        vecs[4]  = '{4'h4, 1'b0, 1'b0, 7'b0011001, 1'b1};
        vecs[5]  = '{4'h5, 1'b1, 1'b0, 7'b0010010, 1'b0};
        vecs[6]  = '{4'h6, 1'b0, 1'b0, 7'b0000010, 1'b1};
        vecs[7]  = '{4'h7, 1'b1, 1'b0, 7'b1111000, 1'b0};
        vecs[8]  = '{4'h8, 1'b0, 1'b0, 7'b0000000, 1'b1};
        vecs[9]  = '{4'h9, 1'b1, 1'b0, 7'b0010000, 1'b0};
        vecs[10] = '{4'hA, 1'b0, 1'b0, 7'b0001000, 1'b1};
        vecs[11] = '{4'hB, 1'b1, 1'b0, 7'b0000011, 1'b0};
        vecs[12] = '{4'hC, 1'b0, 1'b0, 7'b1000110, 1'b1};
        vecs[13] = '{4'hD, 1'b1, 1'b0, 7'b0100001, 1'b0};
        vecs[14] = '{4'hE, 1'b0, 1'b0, 7'b0000110, 1'b1};
        vecs[15] = '{4'hF, 1'b1, 1'b0, 7'b0001110, 1'b0};
        vecs[16] = '{4'h8, 1'b1, 1'b1, 7'b1111111, 1'b1};
        vecs[17] = '{4'h0, 1'b0, 1'b1, 7'b1111111, 1'b1};

        // Reset hold and release
        reset = 1'b0;
        repeat (3) step();
        check("rst_anode", anode, 4'b1111);
        check("rst_cathode", cathode, 7'b1111111);
        check("rst_dp", dp, 1'b1);
        check("rst_pending", pending, 1'b0);
        check("rst_tick", frame_tick, 1'b0);
        reset = 1'b1;
        step();
        check("rel_anode", anode, 4'b1110);
        check("rel_cathode", cathode, 7'b1111111);

        // Idle scan: four cycles per slot, tick after each 16-cycle frame's last edge
        for (int k = 1; k <= 32; k++) begin
            step();
            check("scan_anode", anode, amap(2'((k / 4) % 4)));
            check("scan_tick", frame_tick, (k % 16) == 15);
        end

        // Write 1,2,3,F with dp on digit 2, then commit
        wr(2'd0, 4'h1, 1'b0, 1'b0);
        wr(2'd1, 4'h2, 1'b0, 1'b0);
        wr(2'd2, 4'h3, 1'b1, 1'b0);
        wr(2'd3, 4'hF, 1'b0, 1'b0);
        do_commit();
        check("t3_pend_set", pending, 1'b1);
        wait_bnd();
        check("t3_pend_hold", pending, 1'b1);
        step();
        check("t3_pend_clr", pending, 1'b0);
        check("t3_tick", frame_tick, 1'b1);
        for (int k = 0; k < 16; k++) begin
            step();
            check("t3_anode", anode, amap(2'(k / 4)));
            check("t3_cathode", cathode, exp3[k / 4]);
            check("t3_dp", dp, (k / 4) != 2);
        end

        // Decode table on digit 0
        for (int v = 0; v < 18; v++) begin
            wr(2'd0, vecs[v].d, vecs[v].p, vecs[v].b);
            do_commit();
            wait_bnd();
            step();
            step();
            check("tbl_anode", anode, 4'b1110);
            check("tbl_cathode", cathode, vecs[v].seg);
            check("tbl_dp", dp, vecs[v].dpo);
            check("tbl_pending", pending, 1'b0);
        end

        // Tear-free: write after commit is taken; write in boundary cycle is not
        do_commit();
        wr(2'd0, 4'h8, 1'b0, 1'b0);
        wait_bnd();
        wr(2'd0, 4'h5, 1'b0, 1'b0);
        check("t4_pend_clr", pending, 1'b0);
        step();
        check("t4_d0_8", cathode, 7'b0000000);
        wait_bnd();
        step();
        step();
        check("t4_d0_hold", cathode, 7'b0000000);
        do_commit();
        wait_bnd();
        step();
        step();
        check("t4_d0_5", cathode, 7'b0010010);

        // Commit in the boundary cycle with nothing pending defers one frame
        wr(2'd1, 4'hA, 1'b0, 1'b0);
        wait_bnd();
        check("t5_pend_pre", pending, 1'b0);
        do_commit();
        check("t5_pend", pending, 1'b1);
        repeat (5) step();
        check("t5_old_anode", anode, 4'b1101);
        check("t5_old_cathode", cathode, 7'b0100100);
        do_commit();
        wait_bnd();
        check("t5_pend_hold", pending, 1'b1);
        step();
        check("t5_pend_clr", pending, 1'b0);
        repeat (5) step();
        check("t5_new_anode", anode, 4'b1101);
        check("t5_new_cathode", cathode, 7'b0001000);

        // Reset mid-slot with a commit pending
        do_commit();
        step();
        check("t6_pend", pending, 1'b1);
        reset = 1'b0;
        step();
        check("t6_rst_pending", pending, 1'b0);
        check("t6_rst_anode", anode, 4'b1111);
        check("t6_rst_cathode", cathode, 7'b1111111);
        check("t6_rst_dp", dp, 1'b1);
        check("t6_rst_tick", frame_tick, 1'b0);
        reset = 1'b1;
        for (int k = 0; k < 16; k++) begin
            step();
            check("t6_blank_cathode", cathode, 7'b1111111);
            check("t6_blank_dp", dp, 1'b1);
            check("t6_blank_pend", pending, 1'b0);
        end

        // Random traffic against the model, with occasional resets
        for (int k = 0; k < 600; k++) begin
            wr_en    = ($urandom_range(0, 3) == 0);
            wr_addr  = 2'($urandom_range(0, 3));
            wr_data  = 4'($urandom_range(0, 15));
            wr_dp    = 1'($urandom_range(0, 1));
            wr_blank = ($urandom_range(0, 4) == 0);
            commit   = ($urandom_range(0, 7) == 0);
            reset    = ($urandom_range(0, 149) != 0);
            step();
        end
        wr_en = 1'b0; commit = 1'b0; reset = 1'b1;
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
